line_buffer_3row: RTL and testbench

LINE_BUFFER_3ROW -- requirements
Module: line_buffer_3row

---
 rtl/conv2d_pkg.sv | 16 +
 rtl/line_mem.sv | 26 ++
 rtl/line_buffer_3row.sv | 114 +++++++++++
 tb/tb_line_buffer_3row.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv2d_pkg.sv
// Shared defaults and counter-width helpers for the conv2d datapath.
// Optional top zero padding is enabled with LINEBUF_ZERO_PAD_EN.
package conv2d_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int IMG_WIDTH_DEF  = 64;
    localparam int IMG_HEIGHT_DEF = 64;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int COL_W_DEF = cnt_w(IMG_WIDTH_DEF);
    localparam int ROW_W_DEF = cnt_w(IMG_HEIGHT_DEF);

endpackage

// File: rtl/line_mem.sv
// One line of pixel storage: single address, read-before-write.
// Contents are deliberately not reset.
module line_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 64,
    parameter int ADDR_W     = 6
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            addr,
    input  logic signed [DATA_WIDTH-1:0] wdata,
    output logic signed [DATA_WIDTH-1:0] rdata
);

    logic signed [DATA_WIDTH-1:0] mem [DEPTH];

    // Async read sees the old word; the write lands on the edge.
    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/line_buffer_3row.sv
// Three-row line buffer feeding a 3x3 window, raster-order input.
// Define LINEBUF_ZERO_PAD_EN to zero the missing rows at frame top.
module line_buffer_3row
    import conv2d_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input  logic                         clk,
    input  logic                         Rst_linebuf,
    input  logic                         in_sof,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_pixel,
    output logic signed [DATA_WIDTH-1:0] out_row_n,
    output logic signed [DATA_WIDTH-1:0] out_row_n_1,
    output logic signed [DATA_WIDTH-1:0] out_row_n_2,
    output logic                         Wr_window,
    output logic                         Shift_window,
    output logic                         win_valid,
    output logic                         frame_done
);

    localparam int CW = cnt_w(IMG_WIDTH);
    localparam int RW = cnt_w(IMG_HEIGHT);

    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0] col_q;
    logic [CW-1:0] col_c;
    logic [RW-1:0] row_q;
    logic [RW-1:0] row_c;
    logic          col_wrap;
    logic          row_wrap;
    logic          win_hit;

    logic signed [DATA_WIDTH-1:0] rd_a;
    logic signed [DATA_WIDTH-1:0] rd_b;
    logic signed [DATA_WIDTH-1:0] row1_c;
    logic signed [DATA_WIDTH-1:0] row2_c;

    // A qualified SOF forces this pixel to (0,0).
    assign col_c    = (in_valid && in_sof) ? '0 : col_q;
    assign row_c    = (in_valid && in_sof) ? '0 : row_q;
    assign col_wrap = (col_c == LAST_COL);
    assign row_wrap = (row_c == LAST_ROW);
    assign win_hit  = (row_c >= ROW_TWO) && (col_c >= COL_TWO);

    line_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_WIDTH),
        .ADDR_W     (CW)
    ) u_line_a (
        .clk   (clk),
        .we    (in_valid),
        .addr  (col_c),
        .wdata (in_pixel),
        .rdata (rd_a)
    );

    line_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_WIDTH),
        .ADDR_W     (CW)
    ) u_line_b (
        .clk   (clk),
        .we    (in_valid),
        .addr  (col_c),
        .wdata (rd_a),
        .rdata (rd_b)
    );

`ifdef LINEBUF_ZERO_PAD_EN
    assign row1_c = (row_c == '0) ? '0 : rd_a;
    assign row2_c = (row_c < ROW_TWO) ? '0 : rd_b;
`else
    assign row1_c = rd_a;
    assign row2_c = rd_b;
`endif

    always_ff @(posedge clk or negedge Rst_linebuf) begin
        if (!Rst_linebuf) begin
            col_q        <= '0;
            row_q        <= '0;
            out_row_n    <= '0;
            out_row_n_1  <= '0;
            out_row_n_2  <= '0;
            Wr_window    <= 1'b0;
            Shift_window <= 1'b0;
            win_valid    <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            Wr_window    <= in_valid;
            Shift_window <= in_valid;
            win_valid    <= in_valid && win_hit;
            frame_done   <= in_valid && col_wrap && row_wrap;
            if (in_valid) begin
                out_row_n   <= in_pixel;
                out_row_n_1 <= row1_c;
                out_row_n_2 <= row2_c;
                col_q       <= col_wrap ? '0 : col_c + 1'b1;
                if (col_wrap) begin
                    row_q <= row_wrap ? '0 : row_c + 1'b1;
                end else begin
                    row_q <= row_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_3row.sv
// Self-checking bench for line_buffer_3row on a 4x4 image.
// Honours LINEBUF_ZERO_PAD_EN when defined for the build.
module tb_line_buffer_3row;

    localparam int DW = 16;
    localparam int W  = 4;
    localparam int H  = 4;

    logic                 clk;
    logic                 rst_n;
    logic                 in_sof;
    logic                 in_valid;
    logic signed [DW-1:0] in_pixel;
    logic signed [DW-1:0] out_row_n;
    logic signed [DW-1:0] out_row_n_1;
    logic signed [DW-1:0] out_row_n_2;
    logic                 wr_w;
    logic                 sh_w;
    logic                 win_valid;
    logic                 frame_done;

    line_buffer_3row #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk          (clk),
        .Rst_linebuf  (rst_n),
        .in_sof       (in_sof),
        .in_valid     (in_valid),
        .in_pixel     (in_pixel),
        .out_row_n    (out_row_n),
        .out_row_n_1  (out_row_n_1),
        .out_row_n_2  (out_row_n_2),
        .Wr_window    (wr_w),
        .Shift_window (sh_w),
        .win_valid    (win_valid),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference: pixel position from count since SOF/reset, and
    // per-column history of the last two pixels seen in that column.
    int                   p;
    logic signed [DW-1:0] h1 [W];
    logic signed [DW-1:0] h2 [W];
    bit                   k1 [W];
    bit                   k2 [W];
    logic signed [DW-1:0] m_n, m_1, m_2;
    bit                   ok1, ok2;
    logic                 m_wr, m_win, m_fd;

    typedef struct {
        logic                 sof;
        logic signed [DW-1:0] pix;
        logic                 win;
        logic                 fd;
    } vec_t;

    vec_t vec [16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        p = 0;
        m_n = '0; m_1 = '0; m_2 = '0;
        ok1 = 1; ok2 = 1;
        m_wr = 0; m_win = 0; m_fd = 0;
    endtask

    task automatic model_accept(input logic sof,
                                input logic signed [DW-1:0] pix);
        int r, c;
        if (sof) p = 0;
        r = (p / W) % H;
        c = p % W;
        m_n = pix;
        m_1 = h1[c]; ok1 = k1[c];
        m_2 = h2[c]; ok2 = k2[c];
`ifdef LINEBUF_ZERO_PAD_EN
        if (r == 0) begin m_1 = '0; ok1 = 1; end
        if (r < 2)  begin m_2 = '0; ok2 = 1; end
`endif
        h2[c] = h1[c]; k2[c] = k1[c];
        h1[c] = pix;   k1[c] = 1;
        m_wr  = 1;
        m_win = (r >= 2) && (c >= 2);
        m_fd  = (r == H - 1) && (c == W - 1);
        p = (p + 1) % (W * H);
    endtask

    task automatic check_all();
        chk("row_n", out_row_n, m_n);
        if (ok1) chk("row_n_1", out_row_n_1, m_1);
        if (ok2) chk("row_n_2", out_row_n_2, m_2);
        chk("wr_window", wr_w, m_wr);
        chk("shift_window", sh_w, m_wr);
        chk("win_valid", win_valid, m_win);
        chk("frame_done", frame_done, m_fd);
    endtask

    task automatic step(input logic v, input logic sof,
                        input logic signed [DW-1:0] pix);
        in_valid = v;
        in_sof   = sof;
        in_pixel = pix;
        @(posedge clk);
        if (v) begin
            model_accept(sof, pix);
        end else begin
            m_wr = 0; m_win = 0; m_fd = 0;
        end
        #1;
        check_all();
    endtask

    int wins, fds;

    initial begin
        for (int i = 0; i < W; i++) begin
            k1[i] = 0; k2[i] = 0; h1[i] = '0; h2[i] = '0;
        end
        for (int i = 0; i < 16; i++) begin
            vec[i].sof = (i == 0);
            vec[i].pix = DW'(i + 1);
            vec[i].win = (i == 10) || (i == 11) || (i == 14) || (i == 15);
            vec[i].fd  = (i == 15);
        end

        rst_n = 0; in_valid = 0; in_sof = 0; in_pixel = '0;
        model_reset();
        #12;
        check_all();
        rst_n = 1;

        // Frame 1 from the table.
        wins = 0; fds = 0;
        for (int i = 0; i < 16; i++) begin
            step(1, vec[i].sof, vec[i].pix);
            chk("tbl_win", win_valid, vec[i].win);
            chk("tbl_fd", frame_done, vec[i].fd);
            if (win_valid) wins++;
            if (frame_done) fds++;
            if (i == 10) begin
                chk("px11_n", out_row_n, 11);
                chk("px11_n1", out_row_n_1, 7);
                chk("px11_n2", out_row_n_2, 3);
            end
        end
        chk("win_count", wins, 4);
        chk("fd_count", fds, 1);
        step(0, 0, '0);
        chk("fd_one_cycle", frame_done, 0);

        // Frame 2: top rows see frame 1 data unless padded.
        for (int i = 0; i < 16; i++) begin
            step(1, 0, DW'(i + 1));
            if (i == 1) begin
`ifdef LINEBUF_ZERO_PAD_EN
                chk("f2_px2_n1", out_row_n_1, 0);
                chk("f2_px2_n2", out_row_n_2, 0);
`else
                chk("f2_px2_n1", out_row_n_1, 14);
                chk("f2_px2_n2", out_row_n_2, 10);
`endif
            end
        end

        // SOF restart at (1,2).
        for (int i = 0; i < 6; i++) step(1, i == 0, DW'(50 + i));
        step(0, 1, DW'(77));
        step(1, 1, DW'(100));
        chk("sof_n", out_row_n, 100);
        chk("sof_win", win_valid, 0);
        fds = 0;
        for (int i = 0; i < 15; i++) begin
            step(1, 0, DW'(200 + i));
            if (frame_done) fds++;
        end
        chk("sof_fd_last", frame_done, 1);
        chk("sof_fd_count", fds, 1);

        // Reset mid-frame after pixel 6.
        for (int i = 0; i < 6; i++) step(1, i == 0, DW'(i + 1));
        in_valid = 0;
        #1;
        rst_n = 0;
        #1;
        model_reset();
        check_all();
        chk("rst_n1", out_row_n_1, 0);
        chk("rst_n2", out_row_n_2, 0);
        #2;
        rst_n = 1;
        fds = 0;
        for (int i = 0; i < 16; i++) begin
            step(1, 0, DW'(300 + i));
            if (frame_done) fds++;
            if (i == 9) chk("rst_no_fd", fds, 0);
        end
        chk("rst_fd_last", frame_done, 1);
        chk("rst_fd_count", fds, 1);

        // Randomized gaps, pixels and occasional SOF.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) != 0,
                 $urandom_range(0, 40) == 0,
                 DW'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
